// File: rtl/atetris_rom_pkg.sv
// Shared types and constants for the ROM server and its cache slots.
package atetris_rom_pkg;

  localparam int MEM_AW = 23;

  localparam logic [MEM_AW-1:0] PROM_BASE_DEF = 23'h000000;
  localparam logic [MEM_AW-1:0] CROM_BASE_DEF = 23'h008000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CFETCH = 2'd1,
    ST_PFETCH = 2'd2
  } state_e;

endpackage

// File: rtl/atetris_rom_slot.sv
// Single-entry cache slot: tag, valid bit and one 16-bit word with hit compare.
module atetris_rom_slot #(
  parameter int TAG_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [TAG_W-1:0] lookup_tag,
  input  logic             load,
  input  logic [TAG_W-1:0] load_tag,
  input  logic [15:0]      load_data,
  output logic             hit,
  output logic [15:0]      data
);

  logic [TAG_W-1:0] tag_q, tag_d;
  logic             valid_q, valid_d;
  logic [15:0]      data_q, data_d;

  // Next-state: a load overwrites the whole entry; nothing ever clears valid.
  always_comb begin
    tag_d   = tag_q;
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      tag_d   = load_tag;
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  // Slot registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      tag_q   <= tag_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign hit  = valid_q && (tag_q == lookup_tag);
  assign data = data_q;

endmodule

// File: rtl/atetris_rom_server.sv
// Serves program and character ROM reads from a shared word-wide backend.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | both clients hit, or choosing which miss to service
// ST_CFETCH | character fetch: raise request, wait for the ack
// ST_PFETCH | program fetch: raise request, wait for the ack
//
// Character misses win over program misses. A fetch always completes for the
// tag captured on entry, even if the client address has since moved on.
module atetris_rom_server
  import atetris_rom_pkg::*;
#(
  parameter logic [MEM_AW-1:0] PROM_BASE = PROM_BASE_DEF,
  parameter logic [MEM_AW-1:0] CROM_BASE = CROM_BASE_DEF
) (
  input  logic              MCLK,
  input  logic              RESET_N,
  input  logic [15:0]       PRAD,
  output logic [7:0]        PRDT,
  output logic              PRDY,
  input  logic [15:0]       CRAD,
  output logic [15:0]       CRDT,
  output logic              CRDY,
  output logic              MEM_REQ,
  output logic [MEM_AW-1:0] MEM_ADDR,
  input  logic              MEM_ACK,
  input  logic [15:0]       MEM_DQ
);

  state_e            state_q, state_d;
  logic [15:0]       pend_q, pend_d;
  logic              mem_req_q, mem_req_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;

  logic              p_hit, c_hit;
  logic [15:0]       p_word, c_word;
  logic              ack_ok, p_load, c_load;

  // An ack only counts while our request is outstanding.
  assign ack_ok = mem_req_q && MEM_ACK;
  assign p_load = (state_q == ST_PFETCH) && ack_ok;
  assign c_load = (state_q == ST_CFETCH) && ack_ok;

  atetris_rom_slot #(.TAG_W(15)) u_pslot (
    .clk        (MCLK),
    .rst_n      (RESET_N),
    .lookup_tag (PRAD[15:1]),
    .load       (p_load),
    .load_tag   (pend_q[14:0]),
    .load_data  (MEM_DQ),
    .hit        (p_hit),
    .data       (p_word)
  );

  atetris_rom_slot #(.TAG_W(16)) u_cslot (
    .clk        (MCLK),
    .rst_n      (RESET_N),
    .lookup_tag (CRAD),
    .load       (c_load),
    .load_tag   (pend_q),
    .load_data  (MEM_DQ),
    .hit        (c_hit),
    .data       (c_word)
  );

  // Next-state and backend request generation.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (!c_hit) begin
          state_d = ST_CFETCH;
          pend_d  = CRAD;
        end else if (!p_hit) begin
          state_d = ST_PFETCH;
          pend_d  = {1'b0, PRAD[15:1]};
        end
      end
      ST_CFETCH: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_addr_d = CROM_BASE + {7'd0, pend_q};
        end else if (MEM_ACK) begin
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_PFETCH: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_addr_d = PROM_BASE + {8'd0, pend_q[14:0]};
        end else if (MEM_ACK) begin
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, pending tag and backend request registers.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign PRDT     = PRAD[0] ? p_word[15:8] : p_word[7:0];
  assign PRDY     = p_hit;
  assign CRDT     = c_word;
  assign CRDY     = c_hit;
  assign MEM_REQ  = mem_req_q;
  assign MEM_ADDR = mem_addr_q;

endmodule
